// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between burst requesters, the arbiter and the FIFO
// write-pointer logic.
//   req/last/data : requester beat valid, end-of-burst and beat data
//   ready         : per-requester beat accepted this cycle
//   gnt/busy      : registered one-hot grant and busy flag
//   winc/wdata    : FIFO write enable and data; wfull is the FIFO full flag
interface fifo_wr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       last;
   logic [NREQ*DSIZE-1:0] data;
   logic [NREQ-1:0]       ready;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  wfull;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;

   modport slave (
      input  req, last, data, wfull,
      output ready, gnt, busy, winc, wdata
   );

   modport master (
      output req, last, data, wfull,
      input  ready, gnt, busy, winc, wdata
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port.
// Ports: wclk, wrst (async active-high), bus (slave side of fifo_wr_arbiter_if).
module fifo_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int DSIZE    = 8,
   parameter int MAXBURST = 8
) (
   input  logic              wclk,
   input  logic              wrst,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAXBURST + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]      state;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gidx;
   logic [PW-1:0]   rr_ptr;
   logic [CW-1:0]   beat_cnt;

   logic [PW-1:0]    win;
   logic             any_req;
   logic [NREQ-1:0]  ready;
   logic             winc;
   logic             rel;
   logic [DSIZE-1:0] wdata;

   assign any_req = |bus.req;

   // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
   always_comb begin
      logic found;
      int   j;
      found = 1'b0;
      win   = '0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && bus.req[j]) begin
            found = 1'b1;
            win   = PW'(j);
         end
      end
   end

   // gnt is zero outside BUSY, so no state term is needed here.
   assign ready = gnt & bus.req & {NREQ{~bus.wfull}};
   assign winc  = |ready;

   assign rel = winc &&
                ((|(gnt & bus.last)) ||
                 (beat_cnt == CW'(MAXBURST - 1)));

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) wdata = wdata | bus.data[i*DSIZE +: DSIZE];
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state    <= IDLE;
         gnt      <= '0;
         gidx     <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= BUSY;
                  gnt      <= NREQ'(1) << win;
                  gidx     <= win;
                  beat_cnt <= '0;
               end
            end
            BUSY: begin
               if (rel) begin
                  state    <= IDLE;
                  gnt      <= '0;
                  beat_cnt <= '0;
                  rr_ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
               end else if (winc) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

   assign bus.ready = ready;
   assign bus.gnt   = gnt;
   assign bus.busy  = (state == BUSY);
   assign bus.winc  = winc;
   assign bus.wdata = wdata;
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO write-pointer domain among NREQ burst requesters. Sits in the write clock domain, directly ahead of the write-pointer/full logic. Drives winc/wdata from the granted requester and honours wfull back-pressure. Holds a grant for a whole burst, up to MAXBURST beats, then re-arbitrates.

Parameters:
NREQ, 4, number of requesters (>=2)
DSIZE, 8, data width per beat
MAXBURST, 8, max beats per grant before forced release (>=1)

Ports:
wclk  in  1  write-domain clock
wrst  in  1  asynchronous, active-high reset
wfull  in  1  FIFO full flag from write-pointer logic (registered, wclk domain)
req  in  NREQ  per-requester beat valid
last  in  NREQ  per-requester end-of-burst marker, qualified by req
data  in  NREQ*DSIZE  per-requester beat data; requester i at bits [i*DSIZE +: DSIZE]
ready  out  NREQ  per-requester beat accepted this cycle (combinational)
gnt  out  NREQ  registered one-hot grant; all-zero when idle
busy  out  1  high in BUSY state
winc  out  1  FIFO write enable
wdata  out  DSIZE  FIFO write data

Behaviour:
- Reset (wrst=1, async): state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, busy=0. Outputs ready, winc and wdata follow combinationally and are therefore 0.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - if |req: search req starting at index rr_ptr, wrapping modulo NREQ; first set bit wins.
  - next cycle: gnt=onehot(winner), state=BUSY, beat_cnt=0.
  - Minimum latency from req rising to first winc is one cycle.
- BUSY:
  - ready[i] = gnt[i] & req[i] & ~wfull.
  - winc = |ready.
  - wdata = data of the granted index, regardless of req or wfull.
  - On each accepted beat: beat_cnt increments.
  - Release when an accepted beat has last=1, or when it is beat number MAXBURST (beat_cnt == MAXBURST-1).
  - On release: state=IDLE, gnt=0, rr_ptr=(granted index+1) mod NREQ.
  - The cycle after a release is always an IDLE arbitration cycle: one bubble per burst.
- wfull=1 in BUSY: ready=0 and winc=0. Grant, beat_cnt and state are held. No timeout.
- Granted requester drops req mid-burst: grant is held and no beats are written until req returns. Only last or MAXBURST releases the grant.
- last without req is ignored. last on a stalled beat (wfull=1) does not release.
- Non-granted requesters always see ready=0, and their req/last are ignored.
- Forced release at MAXBURST: the requester is not told. Its remaining beats form a new burst that must win arbitration again, so other requesters get a turn.
- Width rules:
  - beat_cnt is clog2(MAXBURST+1) bits.
  - rr_ptr is clog2(NREQ) bits and wraps modulo NREQ (NREQ need not be a power of two).
- winc must never be asserted while wfull=1, independent of downstream gating.
- gnt is always one-hot or zero. busy == |gnt.
- Reset asserted mid-burst: immediate return to reset values. The partial burst is abandoned with no further winc.

Test Plan:
1. Reset with req=4'b1111 held -> during wrst: gnt=0, winc=0. After release: gnt=0001 in the first cycle, winc=1 on the following beats.
2. Single requester: req[2] 3 beats, data 0xA1/0xA2/0xA3, last on 3rd, wfull=0 -> gnt=0100 one cycle after req. Three consecutive winc cycles with wdata A1, A2, A3. Then gnt=0, rr_ptr=3.
3. All four requesters continuously request 1-beat bursts from reset -> grant order 0,1,2,3,0. Each grant produces exactly one winc, followed by one idle cycle.
4. wfull asserted for 2 cycles during beat 2 of a 4-beat burst -> winc=0 and ready=0 for those 2 cycles. gnt is unchanged. Beats 2-4 are written afterwards with no data loss or duplication.
5. MAXBURST=8, requester 1 streams 12 beats with last only on beat 12, requester 3 also requesting -> 8 beats written, then the grant moves to 3. Requester 1 regains the grant later and writes its remaining 4 beats.
6. wrst pulsed after beat 2 of a 5-beat burst -> gnt=0 and winc=0 asynchronously. After release, arbitration restarts from rr_ptr=0.
